rom_sdram_arbiter: RTL

- Shares the single toggle-handshake SDRAM ROM port between three requesters:
  - the ioctl download writer;
  - the main CPU ROM reader;
  - the graphics/sound ROM reader.
- Sits between data_io/core and the sdram controller in the arcade top level; clocked at SDRAM rate.
- Serialises byte writes during ROM upload.
- Arbitrates reads round-robin.
- Keeps a one-word hit cache per reader so sequential byte fetches avoid SDRAM accesses.

---
 rtl/rom_sdram_arbiter.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/rom_sdram_arbiter.sv
// Shares the toggle-handshake SDRAM ROM port between the ioctl download writer and
// the CPU / GFX ROM readers, with a one-word hit cache in front of each reader.
module rom_sdram_arbiter #(
    parameter logic [21:0] CPU_BASE  = 22'h000000,
    parameter logic [21:0] GFX_BASE  = 22'h008000,
    parameter logic [24:0] DL_OFFSET = 25'h0
) (
    input  logic        clock_24,
    input  logic        reset,
    input  logic        dl_active,
    input  logic        dl_wr,
    input  logic [24:0] dl_addr,
    input  logic [7:0]  dl_data,
    input  logic        cpu_rd,
    input  logic [15:0] cpu_addr,
    output logic [7:0]  cpu_dout,
    output logic        cpu_valid,
    input  logic        gfx_rd,
    input  logic [15:0] gfx_addr,
    output logic [7:0]  gfx_dout,
    output logic        gfx_valid,
    output logic        mem_req,
    input  logic        mem_ack,
    output logic        mem_we,
    output logic [21:0] mem_addr,
    output logic [1:0]  mem_ds,
    output logic [15:0] mem_din,
    input  logic [15:0] mem_dout,
    output logic        dl_overflow
);

    localparam int unsigned MEM_AW = 22;
    localparam int unsigned TAG_W  = 15;
    localparam int unsigned WORD_W = 16;
    localparam int unsigned DL_AW  = 25;

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t              state;
    logic                dl_wr_q;
    logic                pend;
    logic [MEM_AW-1:0]   pend_addr;
    logic [1:0]          pend_ds;
    logic [WORD_W-1:0]   pend_din;
    logic                wait_rd;
    logic                wait_gfx;
    logic                wait_lsb;
    logic                wait_drop;
    logic [TAG_W-1:0]    wait_tag;
    logic                prio_gfx;
    logic                cpu_cv;
    logic                gfx_cv;
    logic [TAG_W-1:0]    cpu_tag;
    logic [TAG_W-1:0]    gfx_tag;
    logic [WORD_W-1:0]   cpu_cdata;
    logic [WORD_W-1:0]   gfx_cdata;
    logic                cpu_done;
    logic                gfx_done;
    logic [15:0]         cpu_done_addr;
    logic [15:0]         gfx_done_addr;

    logic                dl_edge_c;
    logic [DL_AW-1:0]    dl_rel_c;
    logic [MEM_AW-1:0]   dl_word_c;
    logic                dl_unused_c;
    logic                cpu_new_c;
    logic                gfx_new_c;
    logic                cpu_hit_c;
    logic                gfx_hit_c;
    logic                cpu_miss_c;
    logic                gfx_miss_c;
    logic                pick_gfx_c;
    logic [MEM_AW-1:0]   cpu_word_addr_c;
    logic [MEM_AW-1:0]   gfx_word_addr_c;

    // Download byte mapping; the top two relative address bits fall outside the SDRAM.
    assign dl_edge_c   = dl_wr & ~dl_wr_q;
    assign dl_rel_c    = dl_addr - DL_OFFSET;
    assign dl_word_c   = dl_rel_c[22:1];
    assign dl_unused_c = ^dl_rel_c[24:23];

    // A held request that already produced valid is not a new request.
    assign cpu_new_c  = cpu_rd & ~(cpu_done & (cpu_addr == cpu_done_addr));
    assign gfx_new_c  = gfx_rd & ~(gfx_done & (gfx_addr == gfx_done_addr));
    assign cpu_hit_c  = cpu_new_c & cpu_cv & (cpu_tag == cpu_addr[15:1]) & ~dl_active;
    assign gfx_hit_c  = gfx_new_c & gfx_cv & (gfx_tag == gfx_addr[15:1]) & ~dl_active;
    assign cpu_miss_c = cpu_new_c & ~cpu_hit_c & ~dl_active;
    assign gfx_miss_c = gfx_new_c & ~gfx_hit_c & ~dl_active;

    // Priority pointer flips only when a tie is decided, so the previous tie winner loses the next one.
    assign pick_gfx_c = gfx_miss_c & (~cpu_miss_c | prio_gfx);

    assign cpu_word_addr_c = CPU_BASE + MEM_AW'(cpu_addr[15:1]);
    assign gfx_word_addr_c = GFX_BASE + MEM_AW'(gfx_addr[15:1]);

    always_ff @(posedge clock_24 or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            dl_wr_q       <= 1'b0;
            pend          <= 1'b0;
            pend_addr     <= '0;
            pend_ds       <= '0;
            pend_din      <= '0;
            wait_rd       <= 1'b0;
            wait_gfx      <= 1'b0;
            wait_lsb      <= 1'b0;
            wait_drop     <= 1'b0;
            wait_tag      <= '0;
            prio_gfx      <= 1'b0;
            cpu_cv        <= 1'b0;
            gfx_cv        <= 1'b0;
            cpu_tag       <= '0;
            gfx_tag       <= '0;
            cpu_cdata     <= '0;
            gfx_cdata     <= '0;
            cpu_done      <= 1'b0;
            gfx_done      <= 1'b0;
            cpu_done_addr <= '0;
            gfx_done_addr <= '0;
            cpu_dout      <= '0;
            cpu_valid     <= 1'b0;
            gfx_dout      <= '0;
            gfx_valid     <= 1'b0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_ds        <= '0;
            mem_din       <= '0;
            dl_overflow   <= 1'b0;
        end else begin
            dl_wr_q   <= dl_wr;
            cpu_valid <= 1'b0;
            gfx_valid <= 1'b0;
            if (!cpu_rd) cpu_done <= 1'b0;
            if (!gfx_rd) gfx_done <= 1'b0;

            // Cache hits bypass the FSM entirely.
            if (cpu_hit_c) begin
                cpu_valid     <= 1'b1;
                cpu_dout      <= cpu_addr[0] ? cpu_cdata[15:8] : cpu_cdata[7:0];
                cpu_done      <= 1'b1;
                cpu_done_addr <= cpu_addr;
            end
            if (gfx_hit_c) begin
                gfx_valid     <= 1'b1;
                gfx_dout      <= gfx_addr[0] ? gfx_cdata[15:8] : gfx_cdata[7:0];
                gfx_done      <= 1'b1;
                gfx_done_addr <= gfx_addr;
            end

            if (dl_edge_c) begin
                if (pend) begin
                    dl_overflow <= 1'b1;
                end else begin
                    pend      <= 1'b1;
                    pend_addr <= dl_word_c;
                    pend_ds   <= {dl_rel_c[0], ~dl_rel_c[0]};
                    pend_din  <= {dl_data, dl_data};
                end
            end

            case (state)
                ST_IDLE: begin
                    if (pend || dl_edge_c) begin
                        state    <= ST_WAIT;
                        mem_req  <= ~mem_req;
                        mem_we   <= 1'b1;
                        wait_rd  <= 1'b0;
                        mem_addr <= pend ? pend_addr : dl_word_c;
                        mem_ds   <= pend ? pend_ds : {dl_rel_c[0], ~dl_rel_c[0]};
                        mem_din  <= pend ? pend_din : {dl_data, dl_data};
                    end else if (cpu_miss_c || gfx_miss_c) begin
                        state     <= ST_WAIT;
                        mem_req   <= ~mem_req;
                        mem_we    <= 1'b0;
                        mem_ds    <= 2'b11;
                        wait_rd   <= 1'b1;
                        wait_drop <= 1'b0;
                        wait_gfx  <= pick_gfx_c;
                        mem_addr  <= pick_gfx_c ? gfx_word_addr_c : cpu_word_addr_c;
                        wait_tag  <= pick_gfx_c ? gfx_addr[15:1] : cpu_addr[15:1];
                        wait_lsb  <= pick_gfx_c ? gfx_addr[0] : cpu_addr[0];
                        if (cpu_miss_c && gfx_miss_c) prio_gfx <= ~pick_gfx_c;
                    end
                end
                ST_WAIT: begin
                    if (dl_active) wait_drop <= 1'b1;
                    if (mem_ack == mem_req) begin
                        state <= ST_IDLE;
                        if (!wait_rd) begin
                            pend <= 1'b0;
                        end else if (!wait_drop && !dl_active) begin
                            if (wait_gfx) begin
                                gfx_cv        <= 1'b1;
                                gfx_tag       <= wait_tag;
                                gfx_cdata     <= mem_dout;
                                gfx_valid     <= 1'b1;
                                gfx_dout      <= wait_lsb ? mem_dout[15:8] : mem_dout[7:0];
                                gfx_done      <= 1'b1;
                                gfx_done_addr <= gfx_addr;
                            end else begin
                                cpu_cv        <= 1'b1;
                                cpu_tag       <= wait_tag;
                                cpu_cdata     <= mem_dout;
                                cpu_valid     <= 1'b1;
                                cpu_dout      <= wait_lsb ? mem_dout[15:8] : mem_dout[7:0];
                                cpu_done      <= 1'b1;
                                cpu_done_addr <= cpu_addr;
                            end
                        end
                    end
                end
            endcase

            // Download traffic makes any cached ROM word suspect.
            if (dl_active) begin
                cpu_cv <= 1'b0;
                gfx_cv <= 1'b0;
            end
        end
    end

endmodule
